// File: rtl/dtw_pkg.sv
// Shared DTW definitions: source-writer state encoding, lane geometry
// helpers and the accelerator mode constants used by the reference loader.
package dtw_pkg;

  typedef enum logic [2:0] {
    SRC_IDLE    = 3'd0,
    SRC_LOAD    = 3'd1,
    SRC_UNPACK  = 3'd2,
    SRC_DISCARD = 3'd3,
    SRC_DONE    = 3'd4
  } src_state_t;

  localparam logic MODE_NORMAL   = 1'b0;
  localparam logic MODE_LOAD_REF = 1'b1;

  // Samples carried by one stream beat.
  function automatic int unsigned lanes_of(input int unsigned axis_w, input int unsigned w);
    return axis_w / w;
  endfunction

  // Lane index width; a single-lane stream still gets a 1-bit index held at 0.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int unsigned SRC_LANES_DEF = lanes_of(32, 16);
  localparam int unsigned SRC_LW_DEF    = lane_idx_w(SRC_LANES_DEF);

endpackage

// File: rtl/dtw_lane_sel.sv
// Combinational lane mux: picks sample `lane` out of a packed stream word,
// lane 0 being the least significant WIDTH bits.
module dtw_lane_sel #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int LW    = 1
) (
  input  logic [LANES*WIDTH-1:0] word,
  input  logic [LW-1:0]          lane,
  output logic [WIDTH-1:0]       sample
);

  // Lanes beyond LANES-1 are never addressed; they fall back to zero.
  always_comb begin
    sample = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LW'(i)) sample = word[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/dtw_src_writer.sv
// AXI-Stream to DTW source FIFO writer. Unpacks each beat into LANES samples,
// writes exactly len_in of them, then drops the rest of the packet up to tlast.
// Optional build macro DTW_SRC_ERR_EN enables the sticky short-packet flag on
// err_out; without it err_out is tied low.
module dtw_src_writer
  import dtw_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int AXIS_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rs,
  input  logic [REFMEM_PTR_WIDTH-1:0] len_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        err_out,
  input  logic [AXIS_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  input  logic                        src_fifo_clear_in,
  input  logic                        src_fifo_full,
  output logic                        src_fifo_wren_out,
  output logic [WIDTH-1:0]            src_fifo_data_out
);

  localparam int LANES = int'(lanes_of(AXIS_WIDTH, WIDTH));
  localparam int LW    = int'(lane_idx_w(LANES));
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  src_state_t                  state, state_nx;
  logic [REFMEM_PTR_WIDTH-1:0] len_reg, count, count_inc;
  logic [LW-1:0]               lane;
  logic [AXIS_WIDTH-1:0]       word_reg;
  logic                        seen_last;
  logic                        done_q;
  logic                        ready;
  logic                        write;
  logic                        last_sample;
  logic                        last_lane;

  // count never wraps: len_reg is at most 2^REFMEM_PTR_WIDTH-1.
  assign count_inc   = count + REFMEM_PTR_WIDTH'(1);
  assign last_sample = (count_inc == len_reg);
  assign last_lane   = (lane == LAST_LANE);
  assign write       = (state == SRC_UNPACK) && !src_fifo_full && !src_fifo_clear_in;

  assign s_axis_tready     = ready;
  assign src_fifo_wren_out = write;
  assign busy_out          = (state != SRC_IDLE);
  assign done_out          = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SRC_IDLE;
    else     state <= state_nx;
  end

  // Next-state and stream-ready decode.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      SRC_IDLE: begin
        if (rs) state_nx = (len_in != '0) ? SRC_LOAD : SRC_DONE;
      end
      SRC_LOAD: begin
        ready = 1'b1;
        if (s_axis_tvalid) state_nx = SRC_UNPACK;
      end
      SRC_UNPACK: begin
        if (write) begin
          if (last_sample)    state_nx = seen_last ? SRC_DONE : SRC_DISCARD;
          else if (last_lane) state_nx = seen_last ? SRC_DONE : SRC_LOAD;
        end
      end
      SRC_DISCARD: begin
        ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nx = SRC_DONE;
      end
      SRC_DONE: state_nx = SRC_IDLE;
      default:  state_nx = SRC_IDLE;
    endcase
  end

  // Length latch, beat capture and sample/lane counters; a stalled write holds all.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg   <= '0;
      count     <= '0;
      lane      <= '0;
      word_reg  <= '0;
      seen_last <= 1'b0;
    end else begin
      case (state)
        SRC_IDLE: begin
          if (rs) begin
            len_reg   <= len_in;
            count     <= '0;
            seen_last <= 1'b0;
          end
        end
        SRC_LOAD: begin
          if (s_axis_tvalid) begin
            word_reg  <= s_axis_tdata;
            seen_last <= s_axis_tlast;
            lane      <= '0;
          end
        end
        SRC_UNPACK: begin
          if (write) begin
            count <= count_inc;
            lane  <= last_lane ? '0 : lane + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // done pulse lands the cycle after DONE, i.e. two cycles after the last write.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state == SRC_DONE);
  end

`ifdef DTW_SRC_ERR_EN
  logic err_q;
  logic short_pkt;

  // Stream ended (tlast already seen) with samples still owed.
  assign short_pkt = write && !last_sample && last_lane && seen_last;

  // Sticky short-packet flag, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)                           err_q <= 1'b0;
    else if (state == SRC_IDLE && rs)  err_q <= 1'b0;
    else if (short_pkt)                err_q <= 1'b1;
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  dtw_lane_sel #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .LW   (LW)
  ) u_lane_sel (
    .word  (word_reg),
    .lane  (lane),
    .sample(src_fifo_data_out)
  );

endmodule

// File: doc/dtw_src_writer.md
Name: dtw_src_writer

Overview:
- AXI-Stream ingress stage that feeds the DTW source FIFO. The reference loader drains this same FIFO into reference memory.
- Accepts AXIS_WIDTH-bit beats, unpacks them into WIDTH-bit samples (lane 0 = bits [WIDTH-1:0] first) and pushes exactly len_in samples into the FIFO.
- Surplus beats up to and including tlast are discarded.
- One instance sits per accelerator between the DMA stream and the source FIFO.

Parameters:
- WIDTH, 16, sample width in bits.
- AXIS_WIDTH, 32, stream data width; must be an integer multiple of WIDTH. LANES = AXIS_WIDTH/WIDTH.
- REFMEM_PTR_WIDTH, 20, width of the sample count and len_in.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rs  in  1  start request; sampled in IDLE only.
- len_in  in  REFMEM_PTR_WIDTH  samples to write; latched on start.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse on completion.
- err_out  out  1  short-packet flag (see Optional Feature).
- s_axis_tdata  in  AXIS_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  stream last.
- s_axis_tready  out  1  stream ready.
- src_fifo_clear_in  in  1  FIFO clear from the consumer; FIFO writes are inhibited while it is high.
- src_fifo_full  in  1  FIFO full.
- src_fifo_wren_out  out  1  FIFO write enable.
- src_fifo_data_out  out  WIDTH  FIFO write data.

Behaviour:
- Reset values: state IDLE, count 0, lane 0, word_reg 0, seen_last 0. All outputs 0.
- States: IDLE, LOAD, UNPACK, DISCARD, DONE.
- IDLE:
  - s_axis_tready = 0.
  - On rs=1: latch len_in to len_reg, clear count and seen_last.
  - If len_in != 0, go to LOAD; otherwise go to DONE.
- LOAD:
  - s_axis_tready = 1 (combinational from state).
  - On tvalid && tready: word_reg <= tdata, seen_last <= tlast, lane <= 0, go to UNPACK.
- UNPACK:
  - s_axis_tready = 0.
  - src_fifo_wren_out = !src_fifo_full && !src_fifo_clear_in (combinational).
  - src_fifo_data_out = word_reg lane `lane`.
  - Per write: count++, lane++.
  - On a write with count+1 == len_reg:
    - if seen_last (including tlast on the current beat), go to DONE;
    - otherwise go to DISCARD.
  - On a write at lane == LANES-1 with count+1 < len_reg:
    - if seen_last, go to DONE (short packet);
    - otherwise go to LOAD.
  - FIFO full or clear: stall with state, lane and count held. No data is lost.
- DISCARD:
  - s_axis_tready = 1; accepted beats are dropped.
  - Stay until a beat with tlast is accepted, then go to DONE.
- DONE:
  - done_out = 1 for exactly one cycle; busy_out = 0 from the next cycle.
  - Return to IDLE.
- Write latency: the first FIFO write occurs 2 cycles after rs when tvalid is already high (IDLE→LOAD, LOAD→UNPACK; write in UNPACK).
- Throughput: at most one sample per cycle. One idle beat cycle per word (LOAD state).
- Width rules:
  - count is REFMEM_PTR_WIDTH bits and never wraps, because len_reg ≤ 2^REFMEM_PTR_WIDTH−1.
  - The lane index is clog2(LANES) bits; with LANES=1 it is treated as constant 0.
- Further boundary conditions:
  - rs outside IDLE is ignored.
  - rst mid-operation aborts immediately. A partially unpacked word is lost; the FIFO is not cleared by this block.

Optional Feature:
- Macro: DTW_SRC_ERR_EN.
- With the macro:
  - err_out is a sticky flag, set when tlast ends the stream before len_reg samples are written.
  - Cleared on the next accepted rs or on rst.
- Without the macro: err_out is tied 0. The short-packet path still goes to DONE.

Decomposition:
- Shared package dtw_pkg holds:
  - the state encoding (SRC_IDLE..SRC_DONE, 3 bits);
  - the LANES and lane-index-width localparam computations;
  - the MODE_NORMAL and MODE_LOAD_REF constants shared with the reference loader.
- One natural sub-module, dtw_lane_sel: a combinational lane mux from word_reg and lane to sample.
- FSM and counters stay in the top module.

Test Plan:
- len=5, two beats 0x00020001, 0x00040003, then a third beat 0x00060005 with tlast → FIFO receives 1,2,3,4,5. Sample 6 dropped. done_out pulses once, 2 cycles after the last write.
- len=4, four beats with tlast on the 4th → samples from 2 beats written; beats 3–4 accepted in DISCARD; done_out only after the tlast handshake.
- len=4, src_fifo_full held high for 3 cycles after the 2nd write → wren low during the stall; output sequence unchanged; total written = 4.
- len=6, tlast on 2nd beat → 4 samples written, done_out pulses; err_out=1 with DTW_SRC_ERR_EN, 0 without. The next rs clears err_out.
- len=0 with rs → no tready, no writes; done_out pulses 2 cycles after rs.
- rst asserted mid-UNPACK with len=8 → next cycle: IDLE, all outputs 0. A fresh rs with len=2 writes exactly 2 samples.
